stream_upsizer: RTL

Packs a narrow valid/ready stream of DW_IN-bit beats into DW_IN*SCALE-bit wide words. It is the mirror of the team's stream downsizer: an upsizer followed by a downsizer with equal DW_IN/DW_OUT and SCALE returns the original beat order. Beat 0 of each wide word lands in the least-significant lane. s_last_i flushes a partially filled word early, reporting its lane count and carrying the last flag to the wide side. It sits between narrow byte sources (SPI/camera byte streams) and wide FIFO/memory write paths.

---
 rtl/stream_upsizer_pkg.sv | 14 +
 rtl/stream_upsizer.sv | 78 +++++++
 2 files changed

// File: rtl/stream_upsizer_pkg.sv
// Width helpers shared by the stream width converters.
package stream_upsizer_pkg;

    // Bits needed to hold a lane count of 0..scale.
    function automatic int count_width(input int scale);
        return $clog2(scale + 1);
    endfunction

    // Bits needed for a lane index of 0..scale-1, never less than one.
    function automatic int index_width(input int scale);
        return (scale > 2) ? $clog2(scale) : 1;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs DW_IN-bit beats into DW_IN*SCALE-bit words, beat 0 in the low lane;
// s_last_i flushes a partial word early with its lane count.
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int DW_IN = 8,
    parameter int SCALE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DW_IN-1:0]              s_data_i,
    input  logic                          s_valid_i,
    input  logic                          s_last_i,
    output logic                          s_ready_o,
    output logic [DW_IN*SCALE-1:0]        m_data_o,
    output logic [count_width(SCALE)-1:0] m_count_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i
);

    localparam int IDX_W = index_width(SCALE);
    localparam int CNT_W = count_width(SCALE);

    logic [SCALE-1:0][DW_IN-1:0] data_q;
    logic [IDX_W-1:0]            idx;
    logic                        full;
    logic [CNT_W-1:0]            count_q;
    logic                        last_q;
    logic                        rst_r;
    logic                        wr;
    logic                        rd;
    logic                        done;

    assign s_ready_o = !rst_r && (!full || m_ready_i);
    assign wr        = s_valid_i && s_ready_o;
    assign rd        = full && m_ready_i;
    assign done      = wr && (idx == IDX_W'(SCALE - 1) || s_last_i);

    assign m_data_o  = data_q;
    assign m_count_o = count_q;
    assign m_last_o  = last_q;
    assign m_valid_o = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            idx     <= '0;
            full    <= 1'b0;
            count_q <= '0;
            last_q  <= 1'b0;
            rst_r   <= 1'b1;
        end else begin
            rst_r <= 1'b0;
            if (wr) begin
                // Lane 0 starts a fresh word, so stale lanes are zeroed here.
                for (int k = 0; k < SCALE; k++) begin
                    if (IDX_W'(k) == idx)
                        data_q[k] <= s_data_i;
                    else if (idx == '0)
                        data_q[k] <= '0;
                end
            end
            if (done) begin
                full    <= 1'b1;
                count_q <= CNT_W'(idx) + CNT_W'(1);
                last_q  <= s_last_i;
                idx     <= '0;
            end else begin
                if (wr)
                    idx <= idx + IDX_W'(1);
                if (rd)
                    full <= 1'b0;
            end
        end
    end

endmodule
